// File: rtl/lbp_hist_if.sv
// Histogram read-out stream: one bin index and its count per valid/ready transfer.
// The design drives it through the master modport; the downstream stage uses slave.
interface lbp_hist_if #(
  parameter int CNT_W = 14
);
  logic             hist_valid;
  logic             hist_ready;
  logic [7:0]       hist_bin;
  logic [CNT_W-1:0] hist_count;

  modport master (
    output hist_valid,
    output hist_bin,
    output hist_count,
    input  hist_ready
  );

  modport slave (
    input  hist_valid,
    input  hist_bin,
    input  hist_count,
    output hist_ready
  );
endinterface

// File: rtl/lbp_hist.sv
// LBP code histogram: counts codes of interior pixels, then streams every bin out.
// Optional macro UNIFORM_LBP_EN selects the 59-bin uniform-LBP histogram.
module lbp_hist #(
  parameter int CNT_W      = 14,
  parameter int IMG_W_LOG2 = 7
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      lbp_valid,
  input  logic [2*IMG_W_LOG2-1:0]   lbp_addr,
  input  logic [7:0]                lbp_data,
  input  logic                      finish,
  lbp_hist_if.master                hist,
  output logic                      hist_done,
  output logic [13:0]               sample_cnt,
  output logic                      addr_err
);

`ifdef UNIFORM_LBP_EN
  localparam int NUM_BINS = 59;
`else
  localparam int NUM_BINS = 256;
`endif
  localparam int         BIN_W    = $clog2(NUM_BINS);
  localparam logic [7:0] LAST_BIN = 8'(NUM_BINS - 1);

  localparam logic [1:0] ACCUM = 2'd0;
  localparam logic [1:0] DRAIN = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

`ifdef UNIFORM_LBP_EN
  // Uniform codes (at most two circular transitions) numbered in ascending order; the rest share bin 58.
  function automatic logic [255:0][5:0] build_uni_lut();
    logic [255:0][5:0] lut;
    logic [5:0]        n;
    logic [7:0]        cv;
    n = '0;
    for (int c = 0; c < 256; c++) begin
      cv = 8'(c);
      if ($countones(cv ^ {cv[0], cv[7:1]}) <= 2) begin
        lut[c] = n;
        n      = n + 6'd1;
      end else begin
        lut[c] = 6'd58;
      end
    end
    return lut;
  endfunction

  localparam logic [255:0][5:0] UNI_LUT = build_uni_lut();
`endif

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] bins_q [NUM_BINS];
  logic [CNT_W-1:0] bins_d [NUM_BINS];
  logic             hist_valid_q, hist_valid_d;
  logic [7:0]       hist_bin_q, hist_bin_d;
  logic [CNT_W-1:0] hist_count_q, hist_count_d;
  logic             hist_done_q, hist_done_d;
  logic [13:0]      sample_cnt_q, sample_cnt_d;
  logic             addr_err_q, addr_err_d;

  logic [IMG_W_LOG2-1:0] pix_x, pix_y;
  logic                  addr_ok;
  logic [BIN_W-1:0]      bin_idx;
  logic [BIN_W-1:0]      next_idx;

  assign pix_x = lbp_addr[IMG_W_LOG2-1:0];
  assign pix_y = lbp_addr[2*IMG_W_LOG2-1:IMG_W_LOG2];

  // Only centre pixels with a full 3x3 neighbourhood are valid: not on the first or last row/column.
  assign addr_ok = (pix_x != '0) && (pix_x != '1) && (pix_y != '0) && (pix_y != '1);

`ifdef UNIFORM_LBP_EN
  assign bin_idx = UNI_LUT[lbp_data];
`else
  assign bin_idx = lbp_data;
`endif

  assign next_idx = hist_bin_q[BIN_W-1:0] + BIN_W'(1);

  always_comb begin
    state_d      = state_q;
    bins_d       = bins_q;
    hist_valid_d = hist_valid_q;
    hist_bin_d   = hist_bin_q;
    hist_count_d = hist_count_q;
    hist_done_d  = hist_done_q;
    sample_cnt_d = sample_cnt_q;
    addr_err_d   = addr_err_q;

    case (state_q)
      ACCUM: begin
        if (lbp_valid) begin
          if (addr_ok) begin
            if (bins_q[bin_idx] != '1) begin
              bins_d[bin_idx] = bins_q[bin_idx] + CNT_W'(1);
            end
            if (sample_cnt_q != '1) begin
              sample_cnt_d = sample_cnt_q + 14'd1;
            end
          end else begin
            addr_err_d = 1'b1;
          end
        end
        // The first presented count must include a sample landing in the finish cycle.
        if (finish) begin
          state_d      = DRAIN;
          hist_valid_d = 1'b1;
          hist_bin_d   = '0;
          hist_count_d = bins_d[0];
        end
      end

      DRAIN: begin
        if (lbp_valid) begin
          addr_err_d = 1'b1;
        end
        if (hist_valid_q && hist.hist_ready) begin
          if (hist_bin_q == LAST_BIN) begin
            hist_valid_d = 1'b0;
            hist_done_d  = 1'b1;
            state_d      = DONE;
          end else begin
            hist_bin_d   = hist_bin_q + 8'd1;
            hist_count_d = bins_q[next_idx];
          end
        end
      end

      DONE: begin
        if (lbp_valid) begin
          addr_err_d = 1'b1;
        end
      end

      default: begin
        state_d = ACCUM;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ACCUM;
      for (int i = 0; i < NUM_BINS; i++) begin
        bins_q[i] <= '0;
      end
      hist_valid_q <= 1'b0;
      hist_bin_q   <= '0;
      hist_count_q <= '0;
      hist_done_q  <= 1'b0;
      sample_cnt_q <= '0;
      addr_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      bins_q       <= bins_d;
      hist_valid_q <= hist_valid_d;
      hist_bin_q   <= hist_bin_d;
      hist_count_q <= hist_count_d;
      hist_done_q  <= hist_done_d;
      sample_cnt_q <= sample_cnt_d;
      addr_err_q   <= addr_err_d;
    end
  end

  assign hist.hist_valid = hist_valid_q;
  assign hist.hist_bin   = hist_bin_q;
  assign hist.hist_count = hist_count_q;
  assign hist_done       = hist_done_q;
  assign sample_cnt      = sample_cnt_q;
  assign addr_err        = addr_err_q;

endmodule

// File: tb/tb_lbp_hist.sv
// Directed bench for lbp_hist: table-driven sample vectors plus hand-written drain sequences.
// Honours UNIFORM_LBP_EN the same way the design does (59 bins instead of 256).
module tb_lbp_hist;

  localparam int CNT_W = 4;
  localparam int SAT   = 15;
`ifdef UNIFORM_LBP_EN
  localparam int NUM_BINS = 59;
  localparam int RST_BIN  = 30;
`else
  localparam int NUM_BINS = 256;
  localparam int RST_BIN  = 100;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        lbp_valid;
  logic [13:0] lbp_addr;
  logic [7:0]  lbp_data;
  logic        finish;
  logic        hist_done;
  logic [13:0] sample_cnt;
  logic        addr_err;

  lbp_hist_if #(.CNT_W(CNT_W)) hist_if ();

  lbp_hist #(.CNT_W(CNT_W), .IMG_W_LOG2(7)) dut (
    .clk        (clk),
    .reset      (reset),
    .lbp_valid  (lbp_valid),
    .lbp_addr   (lbp_addr),
    .lbp_data   (lbp_data),
    .finish     (finish),
    .hist       (hist_if),
    .hist_done  (hist_done),
    .sample_cnt (sample_cnt),
    .addr_err   (addr_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          sess;
    logic [13:0] addr;
    logic [7:0]  code;
    bit          acc;
    int          exp_cnt;
    bit          exp_err;
  } vec_t;

  vec_t tbl[$];
  int   total = 0;
  int   bad   = 0;
  int   model_bins[256];
  int   got_bins[256];

`ifdef UNIFORM_LBP_EN
  function automatic bit is_uniform(input logic [7:0] c);
    int t = 0;
    for (int i = 0; i < 8; i++) begin
      if (c[i] != c[(i + 1) % 8]) t++;
    end
    return t <= 2;
  endfunction
`endif

  // Expected bin for a code: identity, or rank among uniform codes with 58 for the rest.
  function automatic int map_code(input logic [7:0] c);
`ifdef UNIFORM_LBP_EN
    int idx = 0;
    for (int v = 0; v < int'(c); v++) begin
      if (is_uniform(8'(v))) idx++;
    end
    return is_uniform(c) ? idx : 58;
`else
    return int'(c);
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic modelAdd(input logic [7:0] code);
    int b;
    b = map_code(code);
    if (model_bins[b] < SAT) model_bins[b]++;
  endtask

  task automatic doReset();
    reset              = 1'b0;
    lbp_valid          = 1'b0;
    lbp_addr           = '0;
    lbp_data           = '0;
    finish             = 1'b0;
    hist_if.hist_ready = 1'b0;
    step();
    step();
    reset = 1'b1;
    for (int i = 0; i < 256; i++) model_bins[i] = 0;
  endtask

  // One sample strobe, then sample count and error flag against the hand-computed vector.
  task automatic applyStimulus(input vec_t v);
    lbp_valid = 1'b1;
    lbp_addr  = v.addr;
    lbp_data  = v.code;
    step();
    lbp_valid = 1'b0;
    if (v.acc) modelAdd(v.code);
    checkOutput("sample_cnt", 32'(sample_cnt), 32'(v.exp_cnt));
    checkOutput("addr_err", 32'(addr_err), 32'(v.exp_err));
  endtask

  task automatic runTable(input int sess);
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].sess == sess) applyStimulus(tbl[i]);
    end
  endtask

  task automatic startDrain();
    finish = 1'b1;
    checkOutput("valid_before_finish", 32'(hist_if.hist_valid), 32'd0);
    step();
    checkOutput("valid_after_finish", 32'(hist_if.hist_valid), 32'd1);
  endtask

  // Walks every bin in order; ready follows a repeating pattern, stalled cycles must hold the bin.
  task automatic drainAll(input logic [3:0] pat, input int plen);
    int  b   = 0;
    int  cyc = 0;
    bit  rdy;
    while (b < NUM_BINS && cyc < 4 * NUM_BINS + 16) begin
      rdy                = pat[cyc % plen];
      hist_if.hist_ready = rdy;
      checkOutput("drain_valid", 32'(hist_if.hist_valid), 32'd1);
      checkOutput("drain_bin", 32'(hist_if.hist_bin), 32'(b));
      checkOutput("drain_count", 32'(hist_if.hist_count), 32'(model_bins[b]));
      checkOutput("drain_done_early", 32'(hist_done), 32'd0);
      got_bins[b] = int'(hist_if.hist_count);
      step();
      if (rdy) b++;
      cyc++;
    end
    if (b < NUM_BINS) checkOutput("drain_timeout", 32'(b), 32'(NUM_BINS));
    hist_if.hist_ready = 1'b0;
    checkOutput("end_valid", 32'(hist_if.hist_valid), 32'd0);
    checkOutput("end_done", 32'(hist_done), 32'd1);
  endtask

  initial begin
    // Session 1: basic accumulation at {1,1} and {5,9}.
    for (int i = 0; i < 3; i++) tbl.push_back('{1, 14'h0081, 8'h00, 1'b1, i + 1, 1'b0});
    for (int i = 0; i < 2; i++) tbl.push_back('{1, 14'h0289, 8'hFF, 1'b1, i + 4, 1'b0});
    // Session 2: a couple of samples for the backpressure drain.
    tbl.push_back('{2, 14'h0387, 8'h03, 1'b1, 1, 1'b0});
    tbl.push_back('{2, 14'h3232, 8'hA5, 1'b1, 2, 1'b0});
    // Session 3: saturation of one bin, sample_cnt keeps counting.
    for (int i = 0; i < 20; i++) begin
      tbl.push_back('{3, 14'(((1 + i) << 7) | (2 + i)), 8'h11, 1'b1, i + 1, 1'b0});
    end
    // Session 4: address filter, border pixels dropped, far interior corner kept.
    tbl.push_back('{4, 14'h0000, 8'h22, 1'b0, 0, 1'b1});
    tbl.push_back('{4, 14'h3F80, 8'h22, 1'b0, 0, 1'b1});
    tbl.push_back('{4, 14'h0FFF, 8'h22, 1'b0, 0, 1'b1});
    tbl.push_back('{4, 14'h0005, 8'h22, 1'b0, 0, 1'b1});
    tbl.push_back('{4, 14'h0102, 8'h22, 1'b1, 1, 1'b1});
    tbl.push_back('{4, 14'h3F7E, 8'h33, 1'b1, 2, 1'b1});
    // Session 6: mapping codes; the 0x00 sample is sent by hand alongside finish.
    tbl.push_back('{6, 14'h0204, 8'h01, 1'b1, 1, 1'b0});
    tbl.push_back('{6, 14'h0285, 8'h05, 1'b1, 2, 1'b0});
    tbl.push_back('{6, 14'h0306, 8'hFF, 1'b1, 3, 1'b0});
    // Session 7: samples for the reset-during-drain sequence.
    tbl.push_back('{7, 14'h050A, 8'd100, 1'b1, 1, 1'b0});
    tbl.push_back('{7, 14'h0A14, 8'd50, 1'b1, 2, 1'b0});

    doReset();
    checkOutput("rst_valid", 32'(hist_if.hist_valid), 32'd0);
    checkOutput("rst_bin", 32'(hist_if.hist_bin), 32'd0);
    checkOutput("rst_count", 32'(hist_if.hist_count), 32'd0);
    checkOutput("rst_done", 32'(hist_done), 32'd0);
    checkOutput("rst_cnt", 32'(sample_cnt), 32'd0);
    checkOutput("rst_err", 32'(addr_err), 32'd0);

    runTable(1);
    startDrain();
    drainAll(4'b0001, 1);
    checkOutput("s1_bin0", 32'(got_bins[0]), 32'd3);
`ifdef UNIFORM_LBP_EN
    checkOutput("s1_binff", 32'(got_bins[57]), 32'd2);
`else
    checkOutput("s1_binff", 32'(got_bins[255]), 32'd2);
`endif
    checkOutput("s1_cnt", 32'(sample_cnt), 32'd5);

    doReset();
    runTable(2);
    startDrain();
    drainAll(4'b1001, 4);

    doReset();
    runTable(3);
    startDrain();
    drainAll(4'b0001, 1);
`ifdef UNIFORM_LBP_EN
    checkOutput("s3_sat", 32'(got_bins[58]), 32'd15);
`else
    checkOutput("s3_sat", 32'(got_bins[17]), 32'd15);
`endif
    checkOutput("s3_cnt", 32'(sample_cnt), 32'd20);

    doReset();
    checkOutput("s4_err_clear", 32'(addr_err), 32'd0);
    runTable(4);
    startDrain();
    drainAll(4'b0001, 1);
`ifndef UNIFORM_LBP_EN
    checkOutput("s4_bin34", 32'(got_bins[34]), 32'd1);
`endif

    // Session 5: sample in the finish cycle counts; a sample during drain does not.
    doReset();
    lbp_valid = 1'b1;
    lbp_addr  = 14'h0183;
    lbp_data  = 8'h7E;
    finish    = 1'b1;
    checkOutput("s5_valid_before", 32'(hist_if.hist_valid), 32'd0);
    step();
    lbp_valid = 1'b0;
    modelAdd(8'h7E);
    checkOutput("s5_valid_rise", 32'(hist_if.hist_valid), 32'd1);
    checkOutput("s5_cnt", 32'(sample_cnt), 32'd1);
    checkOutput("s5_err", 32'(addr_err), 32'd0);
    hist_if.hist_ready = 1'b0;
    finish    = 1'b0;
    lbp_valid = 1'b1;
    lbp_addr  = 14'h0204;
    step();
    lbp_valid = 1'b0;
    checkOutput("s5_late_err", 32'(addr_err), 32'd1);
    checkOutput("s5_late_cnt", 32'(sample_cnt), 32'd1);
    checkOutput("s5_hold_bin", 32'(hist_if.hist_bin), 32'd0);
    drainAll(4'b0001, 1);
`ifndef UNIFORM_LBP_EN
    checkOutput("s5_bin126", 32'(got_bins[126]), 32'd1);
`endif
    lbp_valid = 1'b1;
    step();
    lbp_valid = 1'b0;
    checkOutput("s5_done_cnt", 32'(sample_cnt), 32'd1);
    checkOutput("s5_done_hold", 32'(hist_done), 32'd1);

    // Session 6: mapping, with a bin-0 sample arriving together with finish.
    doReset();
    runTable(6);
    lbp_valid = 1'b1;
    lbp_addr  = 14'h0387;
    lbp_data  = 8'h00;
    finish    = 1'b1;
    step();
    lbp_valid = 1'b0;
    modelAdd(8'h00);
    checkOutput("s6_entry_count", 32'(hist_if.hist_count), 32'd1);
    checkOutput("s6_cnt", 32'(sample_cnt), 32'd4);
    drainAll(4'b0001, 1);
    checkOutput("s6_bin0", 32'(got_bins[0]), 32'd1);
    checkOutput("s6_bin1", 32'(got_bins[1]), 32'd1);
`ifdef UNIFORM_LBP_EN
    checkOutput("s6_bin57", 32'(got_bins[57]), 32'd1);
    checkOutput("s6_bin58", 32'(got_bins[58]), 32'd1);
`else
    checkOutput("s6_bin5", 32'(got_bins[5]), 32'd1);
    checkOutput("s6_bin255", 32'(got_bins[255]), 32'd1);
`endif

    // Session 7: reset while bin RST_BIN is presented, then a fresh drain must be all zeros.
    doReset();
    runTable(7);
    startDrain();
    hist_if.hist_ready = 1'b1;
    for (int c = 0; c < NUM_BINS + 8 && hist_if.hist_bin != 8'(RST_BIN); c++) step();
    checkOutput("s7_reached", 32'(hist_if.hist_bin), 32'(RST_BIN));
    reset  = 1'b0;
    finish = 1'b0;
    step();
    reset = 1'b1;
    hist_if.hist_ready = 1'b0;
    for (int i = 0; i < 256; i++) model_bins[i] = 0;
    checkOutput("s7_valid", 32'(hist_if.hist_valid), 32'd0);
    checkOutput("s7_bin", 32'(hist_if.hist_bin), 32'd0);
    checkOutput("s7_count", 32'(hist_if.hist_count), 32'd0);
    checkOutput("s7_cnt", 32'(sample_cnt), 32'd0);
    checkOutput("s7_done", 32'(hist_done), 32'd0);
    step();
    checkOutput("s7_idle_valid", 32'(hist_if.hist_valid), 32'd0);
    startDrain();
    drainAll(4'b0001, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
